// File: rtl/alu_pkg.sv
// Shared encodings and types for the multicycle ALU execute block.
// Optional build macro consumed by alu_multicycle_exec: ALU_FAST_SHIFT_EN.
package alu_pkg;

  // alu_op class encodings (same as the existing decode)
  localparam logic [2:0] ALU_OP_ADD   = 3'b000;
  localparam logic [2:0] ALU_OP_SLL   = 3'b001;
  localparam logic [2:0] ALU_OP_SRL   = 3'b010;
  localparam logic [2:0] ALU_OP_SRA   = 3'b011;
  localparam logic [2:0] ALU_OP_COMP  = 3'b100;
  localparam logic [2:0] ALU_OP_RTYPE = 3'b111;

  // R-type funct encodings, meaningful only with ALU_OP_RTYPE
  localparam logic [5:0] FUNCT_ADD  = 6'd1;
  localparam logic [5:0] FUNCT_COMP = 6'd2;
  localparam logic [5:0] FUNCT_AND  = 6'd3;
  localparam logic [5:0] FUNCT_XOR  = 6'd4;
  localparam logic [5:0] FUNCT_DIFF = 6'd5;
  localparam logic [5:0] FUNCT_SLL  = 6'd6;
  localparam logic [5:0] FUNCT_SRL  = 6'd7;
  localparam logic [5:0] FUNCT_SRA  = 6'd8;

  typedef enum logic [3:0] {
    OP_ADD,
    OP_COMP,
    OP_AND,
    OP_XOR,
    OP_DIFF,
    OP_SLL,
    OP_SRL,
    OP_SRA,
    OP_ILLEGAL
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  function automatic logic is_shift(op_e op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of alu_op/funct into the internal operation enum.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] alu_op,
  input  logic [5:0] funct,
  output op_e        op
);

  // Map operation class (and funct for R-type) to an op; anything else is illegal
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    op = OP_ILLEGAL;
    case (alu_op)
      ALU_OP_ADD:  op = OP_ADD;
      ALU_OP_SLL:  op = OP_SLL;
      ALU_OP_SRL:  op = OP_SRL;
      ALU_OP_SRA:  op = OP_SRA;
      ALU_OP_COMP: op = OP_COMP;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD:  op = OP_ADD;
          FUNCT_COMP: op = OP_COMP;
          FUNCT_AND:  op = OP_AND;
          FUNCT_XOR:  op = OP_XOR;
          FUNCT_DIFF: op = OP_DIFF;
          FUNCT_SLL:  op = OP_SLL;
          FUNCT_SRL:  op = OP_SRL;
          FUNCT_SRA:  op = OP_SRA;
          default:    op = OP_ILLEGAL;
        endcase
      end
      default: op = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_multicycle_exec.sv
// Multicycle ALU execute stage: valid/ready in, valid/ready out, IDLE/SHIFT/DONE FSM.
// Shifts iterate one bit per cycle unless ALU_FAST_SHIFT_EN is defined, in which
// case a barrel shifter makes every op single-cycle and SHIFT is never entered.
module alu_multicycle_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             illegal
);

  state_e             state, state_nxt;
  op_e                op, op_q;
  logic [SHAMT_W-1:0] shamt, cnt;
  logic [WIDTH-1:0]   calc_res, diff_idx, shift1;
  logic               calc_carry, start_iter;

  alu_op_decode u_decode (
    .alu_op (alu_op),
    .funct  (funct),
    .op     (op)
  );

  assign shamt = op_b[SHAMT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  assign start_iter = 1'b0;
`else
  assign start_iter = is_shift(op) && (shamt != '0);
`endif

  // Index of the lowest differing bit; WIDTH when operands are equal
  always_comb begin
    diff_idx = WIDTH'(WIDTH);
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (op_a[i] ^ op_b[i]) diff_idx = WIDTH'(i);
    end
  end

  // Single-cycle result for the op being accepted (shifts only when shamt==0 or fast build)
  always_comb begin
    calc_res   = '0;
    calc_carry = 1'b0;
    case (op)
      OP_ADD:  {calc_carry, calc_res} = {1'b0, op_a} + {1'b0, op_b};
      OP_COMP: calc_res = ~op_b + WIDTH'(1);
      OP_AND:  calc_res = op_a & op_b;
      OP_XOR:  calc_res = op_a ^ op_b;
      OP_DIFF: calc_res = diff_idx;
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL:  calc_res = op_a << shamt;
      OP_SRL:  calc_res = op_a >> shamt;
      OP_SRA:  calc_res = $signed(op_a) >>> shamt;
`else
      OP_SLL, OP_SRL, OP_SRA: calc_res = op_a;
`endif
      default: calc_res = '0;
    endcase
  end

  // One-bit step of the in-flight shift, applied to the working result
  always_comb begin
    case (op_q)
      OP_SLL:  shift1 = {result[WIDTH-2:0], 1'b0};
      OP_SRL:  shift1 = {1'b0, result[WIDTH-1:1]};
      OP_SRA:  shift1 = {result[WIDTH-1], result[WIDTH-1:1]};
      default: shift1 = result;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_valid) state_nxt = start_iter ? ST_SHIFT : ST_DONE;
      ST_SHIFT: if (cnt == SHAMT_W'(1)) state_nxt = ST_DONE;
      ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: handshake signals decoded from state only
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
  end

  // Datapath: capture on accept, step shifts, hold everything in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_ADD;
      cnt     <= '0;
      result  <= '0;
      zero    <= 1'b0;
      carry   <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q <= op;
            if (start_iter) begin
              cnt     <= shamt;
              result  <= op_a;
              zero    <= 1'b0;
              carry   <= 1'b0;
              illegal <= 1'b0;
            end else begin
              cnt     <= '0;
              result  <= calc_res;
              zero    <= (calc_res == '0);
              carry   <= calc_carry;
              illegal <= (op == OP_ILLEGAL);
            end
          end
        end
        ST_SHIFT: begin
          cnt    <= cnt - SHAMT_W'(1);
          result <= shift1;
          if (cnt == SHAMT_W'(1)) zero <= (shift1 == '0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_multicycle_exec.md
ALU_MULTICYCLE_EXEC -- requirements
Module: alu_multicycle_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal range 8..64).
REQ-002 SHALL have parameter SHAMT_W, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port alu_op  input  3  ALU operation class, same encoding as existing decode.
REQ-008 SHALL have port funct  input  6  R-type function field, used only when alu_op=3'b111.
REQ-009 SHALL have ports op_a, op_b  input  WIDTH  operands (rs, rt/immediate).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have ports zero, carry, illegal  output  1 each  result==0; add carry-out; undecodable op.

Function
REQ-014 Decode SHALL map: alu_op 000 add; 001 sll; 010 srl; 011 sra; 100 comp(op_b); 111 with funct 1..8 = add, comp, and, xor, diff, sll, srl, sra; all else illegal.
REQ-015 comp SHALL be two's complement negation of op_b, WIDTH bits, wrap (comp(0)=0, comp(min)=min).
REQ-016 diff SHALL return index of least-significant set bit of op_a^op_b; if op_a==op_b result SHALL be WIDTH.
REQ-017 Shifts SHALL shift op_a by op_b[SHAMT_W-1:0]; upper op_b bits ignored; sra replicates op_a[WIDTH-1].
REQ-018 add SHALL be modulo 2^WIDTH; carry = bit WIDTH of the unsigned sum; carry SHALL be 0 for all other ops.
REQ-019 FSM states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE.
REQ-020 IDLE: on in_valid, latch operands and decode; non-shift or shamt==0 -> DONE; shift with shamt>0 -> SHIFT.
REQ-021 SHIFT: one bit position per cycle, decrementing a counter; when counter reaches 0 -> DONE.
REQ-022 Latency accept-to-out_valid SHALL be 1 cycle for non-shift ops, shamt+1 cycles for iterative shifts.
REQ-023 DONE: out_valid=1, result/flags stable until out_ready; on out_valid&&out_ready -> IDLE next cycle.
REQ-024 Maximum throughput SHALL be one operation per 2 cycles; no request accepted while in SHIFT or DONE.
REQ-025 Illegal op SHALL complete as non-shift: result=0, zero=1, illegal=1, carry=0.
REQ-026 in_valid deassertion, operand change or alu_op change after acceptance SHALL NOT affect the operation in flight.

Reset
REQ-027 rst_n low SHALL force state IDLE, in_ready=1 after release, out_valid=0, result=0, zero=0, carry=0, illegal=0, counter=0, immediately and regardless of clk.
REQ-028 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid after release.

Configuration
REQ-029 Macro ALU_FAST_SHIFT_EN defined: shifts SHALL use a single-cycle barrel shifter, SHIFT state unused, all ops 1-cycle latency.
REQ-030 Macro ALU_FAST_SHIFT_EN undefined: iterative shift per REQ-021/022; interface identical in both builds.

Structure
REQ-031 Package alu_pkg SHALL hold the alu_op/funct encodings, op enum (ADD, COMP, AND, XOR, DIFF, SLL, SRL, SRA, ILLEGAL) and FSM state typedef.
REQ-032 Decode SHALL be sub-module alu_op_decode (combinational, alu_op+funct -> op enum); datapath and FSM in alu_multicycle_exec.

Verification
REQ-033 WIDTH=32, alu_op=000, a=0xFFFFFFFF, b=1 -> result=0, carry=1, zero=1, out_valid 1 cycle after accept.
REQ-034 alu_op=111 funct=000111 (srl), a=0x80000000, b=4 -> result=0x08000000 after 5 cycles (1 cycle with ALU_FAST_SHIFT_EN); in_ready=0 throughout.
REQ-035 alu_op=111 funct=001000 (sra), a=0x80000000, b=0x24 -> shamt=4, result=0xF8000000.
REQ-036 diff a=0x0000_00F0, b=0x0000_00B0 -> result=6; diff a=b=0x1234 -> result=32.
REQ-037 alu_op=111 funct=001001 -> illegal=1, result=0; then hold out_ready=0 for 3 cycles -> outputs stable, in_ready=0.
REQ-038 Assert rst_n low during SHIFT of sll by 20 -> out_valid=0 immediately, in_ready=1 first cycle after release, no stale result.
